// File: rtl/controle_desloca_dir.sv
// Sequencer for the 8-bit logical right shifter: latches a byte and a count, shifts one
// position per cycle, streams each shifted-out bit and holds the result until acknowledged.
module controle_desloca_dir #(
  parameter int LARG  = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LARG-1:0]  A,
  input  logic [CNT_W-1:0] N,
  input  logic             abort,
  input  logic             ack,
  output logic             busy,
  output logic [LARG-1:0]  Y,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_SHIFT = CNT_W'(LARG);

  state_t           r_state, w_state_nxt;
  logic [LARG-1:0]  r_reg, w_reg_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_bit_out, w_bit_out_nxt;
  logic             r_bit_valid, w_bit_valid_nxt;
  logic [LARG-1:0]  w_desloca;
  logic [CNT_W-1:0] w_n_clamp;

  // DeslocaDir8 datapath: logical right shift by one, zero filled at the MSB.
  assign w_desloca = {1'b0, r_reg[LARG-1:1]};
  assign w_n_clamp = (N > MAX_SHIFT) ? MAX_SHIFT : N;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_reg       <= '0;
      r_cnt       <= '0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_reg       <= w_reg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_out   <= w_bit_out_nxt;
      r_bit_valid <= w_bit_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_reg_nxt       = r_reg;
    w_cnt_nxt       = r_cnt;
    w_bit_out_nxt   = r_bit_out;
    w_bit_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_reg_nxt   = A;
          w_cnt_nxt   = w_n_clamp;
          w_state_nxt = (w_n_clamp == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Abort leaves the partially shifted value visible on Y.
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_reg_nxt       = w_desloca;
          w_bit_out_nxt   = r_reg[0];
          w_bit_valid_nxt = 1'b1;
          if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt <= CNT_W'(1)) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign Y           = r_reg;
  assign bit_out     = r_bit_out;
  assign bit_valid   = r_bit_valid;
  assign o_dbg_state = r_state;

endmodule
